snn_frame_loader: RTL and testbench
===================================

# snn_frame_loader

Parametrised UART frame controller for the SNN top level. It sits between the UART receiver/transmitter pair and the inference core. It collects a fixed-length frame of received bytes into an internal buffer and exposes that buffer to the core through a registered read port. When the core reports its result, the block transmits that result byte over UART and shows it on the LEDs. It replaces the fixed byte-loopback path with frame buffering, an overrun indication, and an optional echo.

## Interface
Parameters:
- DATA_W, 8, width of a UART byte and of each buffer entry.
- FRAME_BYTES, 98, bytes per frame (784 packed 1-bit pixels); legal range 2..1024.
- ADDR_W, $clog2(FRAME_BYTES), buffer address width (derived; do not override).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- rx_rdy  in  1  one-cycle pulse from the UART receiver; rx_data is valid in the same cycle.
- rx_data  in  DATA_W  received byte.
- tx_busy  in  1  high while the UART transmitter is shifting.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  DATA_W  byte to transmit; held stable from the tx_start cycle.
- frame_rdy  out  1  level; a full frame is buffered and the core may read it.
- rd_addr  in  ADDR_W  core read address.
- rd_data  out  DATA_W  registered buffer data for rd_addr.
- result_vld  in  1  one-cycle pulse from the core; result is valid in the same cycle.
- result  in  DATA_W  classification result byte.
- led  out  8  last result; low 8 bits when DATA_W > 8, zero-extended when DATA_W < 8.
- overrun  out  1  sticky; a byte arrived while the buffer was not accepting.

## Operation
- State machine with three states: LOAD, FULL, SEND. Reset state is LOAD.
- LOAD:
  - On rx_rdy, write rx_data to buf[wr_cnt].
  - If wr_cnt == FRAME_BYTES-1, clear wr_cnt to 0 and go to FULL. Otherwise increment wr_cnt.
- FULL:
  - frame_rdy = 1.
  - rx_rdy is ignored: no write, and overrun is set.
  - On result_vld, capture result into res_reg and led, then go to SEND.
- SEND:
  - rx_rdy sets overrun and is otherwise ignored.
  - When tx_busy == 0, pulse tx_start for one cycle with tx_data = res_reg, then go to LOAD.
  - If tx_busy == 1, stay in SEND and keep waiting.
- result_vld outside FULL is ignored; led does not change.
- The read port is active in every state. rd_data <= buf[rd_addr] on each clock.
- rd_addr >= FRAME_BYTES returns an undefined value. The bench must not check it.
- overrun is cleared only by reset.
- Buffer contents are not cleared by reset. Only wr_cnt and the state are reset.

Reset values: tx_start 0, tx_data 0, frame_rdy 0, rd_data 0, led 0, overrun 0, wr_cnt 0, res_reg 0.

Reset mid-operation: a partial frame is discarded (wr_cnt = 0) and any pending SEND is abandoned. tx_start is not asserted in the cycle after reset is released.

## Timing
- Write: rx_rdy sampled at edge N stores the byte at edge N.
- frame_rdy goes high in the cycle after the edge that accepts the last byte.
- Read latency: one cycle from rd_addr to rd_data.
- A read of the address being written in the same cycle returns the old data.
- result_vld at edge N:
  - led updates and the state becomes SEND at edge N.
  - frame_rdy is low from N+1.
  - tx_start is at the earliest high in cycle N+1, if tx_busy is low.
- tx_start is exactly one cycle wide. tx_data holds until the next tx_start.
- The block accepts a new frame byte in the cycle after the tx_start pulse.
- rx_rdy and result_vld in the same FULL cycle:
  - The result is accepted and overrun is set.
  - The byte is dropped.

## Configuration
- SNN_ECHO_EN defined:
  - In LOAD, each accepted byte is echoed: tx_start pulses in the cycle after rx_rdy, with tx_data = rx_data.
  - The echo is issued only if tx_busy == 0 in the rx_rdy cycle. Otherwise the echo is skipped silently; the byte is still stored.
  - The echo of the final frame byte is issued normally.
  - If that echo is still transmitting, SEND waits on tx_busy as usual.
- SNN_ECHO_EN undefined: tx_start occurs only in SEND. The echo logic is absent.

## Test plan
- FRAME_BYTES=4, bytes 0x11,0x22,0x33,0x44:
  - frame_rdy rises one cycle after the 0x44 pulse.
  - rd_addr 0..3 returns 0x11..0x44, each one cycle after its address.
- Full frame loaded, then result_vld with result=0x07 while tx_busy=0:
  - led = 0x07.
  - One tx_start pulse with tx_data = 0x07 in the next cycle.
  - frame_rdy falls, and a new frame loads from address 0.
- Same as above but tx_busy=1 for 20 cycles:
  - tx_start is held off.
  - It pulses in the cycle after tx_busy falls.
- Extra byte 0x55 sent while in FULL:
  - overrun = 1 and stays 1.
  - buf[0] is still 0x11.
  - overrun clears only after rst_n is low for one clock.
- Two bytes sent, then rst_n low for one cycle, then four new bytes 0xA0..0xA3:
  - Reads return 0xA0..0xA3.
  - frame_rdy rises only after the fourth new byte.
- SNN_ECHO_EN defined, byte 0x3C with tx_busy=0:
  - tx_start pulses with tx_data = 0x3C one cycle after rx_rdy.
  - With tx_busy=1 in the rx_rdy cycle, no echo is sent and the byte is still stored.

Source files
------------

// File: rtl/snn_frame_loader_if.sv
// snn_frame_loader_if: bundles the UART-side, core-side and status signals of
// the frame loader. The master modport is the environment (UART pair + core),
// the slave modport is the frame loader itself.
interface snn_frame_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              rx_rdy;
  logic [DATA_W-1:0] rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              frame_rdy;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              result_vld;
  logic [DATA_W-1:0] result;
  logic [7:0]        led;
  logic              overrun;

  modport master (
    output rx_rdy, rx_data, tx_busy, rd_addr, result_vld, result,
    input  tx_start, tx_data, frame_rdy, rd_data, led, overrun
  );

  modport slave (
    input  rx_rdy, rx_data, tx_busy, rd_addr, result_vld, result,
    output tx_start, tx_data, frame_rdy, rd_data, led, overrun
  );
endinterface

// File: rtl/snn_frame_loader.sv
// snn_frame_loader: buffers a FRAME_BYTES-long frame of UART bytes for the SNN
// core, returns the core's result byte over UART and on the LEDs.
// Ports: clk, rst_n (synchronous, active-low); bus (snn_frame_loader_if.slave):
//   rx_rdy/rx_data in, tx_busy in, tx_start/tx_data out, frame_rdy out,
//   rd_addr in / rd_data out (1-cycle registered read), result_vld/result in,
//   led out, overrun out (sticky until reset).
// Optional feature: define SNN_ECHO_EN to echo every accepted frame byte.
module snn_frame_loader #(
  parameter int DATA_W      = 8,
  parameter int FRAME_BYTES = 98,
  parameter int ADDR_W      = $clog2(FRAME_BYTES)
) (
  input logic               clk,
  input logic               rst_n,
  snn_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {LOAD, FULL, SEND} state_t;

  state_t            state;
  state_t            state_nxt;

  // Frame buffer; deliberately not reset.
  logic [DATA_W-1:0] mem [FRAME_BYTES];

  logic [ADDR_W-1:0] wr_cnt;
  logic [DATA_W-1:0] res_reg;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] rd_q;
  logic [7:0]        led_q;
  logic [7:0]        led_nxt;
  logic              overrun_q;

  logic              last_byte;
  logic              wr_en;
  logic              res_take;
  logic              send_fire;
  logic              frame_rdy_c;

  assign last_byte = (wr_cnt == ADDR_W'(FRAME_BYTES - 1));

  // LED shows the low byte of the result, zero-extended for narrow results.
  if (DATA_W >= 8) begin : g_led_trunc
    assign led_nxt = bus.result[7:0];
  end else begin : g_led_ext
    assign led_nxt = {{(8 - DATA_W){1'b0}}, bus.result};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (bus.rx_rdy && last_byte) state_nxt = FULL;
      FULL:    if (bus.result_vld)          state_nxt = SEND;
      SEND:    if (!bus.tx_busy)            state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    wr_en       = (state == LOAD) && bus.rx_rdy;
    res_take    = (state == FULL) && bus.result_vld;
    send_fire   = (state == SEND) && !bus.tx_busy;
    frame_rdy_c = (state == FULL);
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= bus.rx_data;
  end

`ifdef SNN_ECHO_EN
  logic echo_pend;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      res_reg   <= '0;
      led_q     <= '0;
      overrun_q <= 1'b0;
      tx_hold   <= '0;
      rd_q      <= '0;
`ifdef SNN_ECHO_EN
      echo_pend <= 1'b0;
`endif
    end else begin
      // Old data is returned when reading the address being written.
      rd_q <= mem[bus.rd_addr];

      if (wr_en) wr_cnt <= last_byte ? '0 : wr_cnt + 1'b1;

      if (bus.rx_rdy && (state != LOAD)) overrun_q <= 1'b1;

      if (res_take) begin
        res_reg <= bus.result;
        led_q   <= led_nxt;
      end

      // tx_hold keeps the last transmitted byte so tx_data stays put
      // between transmit requests.
`ifdef SNN_ECHO_EN
      echo_pend <= wr_en && !bus.tx_busy;
      if (wr_en && !bus.tx_busy) tx_hold <= bus.rx_data;
      else if (send_fire)        tx_hold <= res_reg;
`else
      if (send_fire) tx_hold <= res_reg;
`endif
    end
  end

  // The result request is combinational on SEND so it can go out in the
  // first cycle after capture; the echo request is one cycle after rx_rdy.
`ifdef SNN_ECHO_EN
  assign bus.tx_start = send_fire || echo_pend;
`else
  assign bus.tx_start = send_fire;
`endif
  assign bus.tx_data   = send_fire ? res_reg : tx_hold;
  assign bus.frame_rdy = frame_rdy_c;
  assign bus.rd_data   = rd_q;
  assign bus.led       = led_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_snn_frame_loader.sv
module tb_snn_frame_loader;
  localparam int DW = 8;
  localparam int FB = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snn_frame_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  snn_frame_loader #(.DATA_W(DW), .FRAME_BYTES(FB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] exp_rd[$];
  logic rd_chk = 1'b0;
  logic rd_pend = 1'b0;
  int m_state = 0;  // 0 LOAD, 1 FULL (SEND resolves inside the result task)
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected transmit bytes and read data as the DUT presents them.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (bus.tx_start === 1'b1) begin
      if (exp_tx.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx_unexpected: tx_start with tx_data %0h, none expected at %0t",
                 bus.tx_data, $time);
      end else begin
        e = exp_tx.pop_front();
        chk("tx_data", 32'(bus.tx_data), 32'(e));
      end
    end
    if (rd_pend) begin
      e = exp_rd.pop_front();
      chk("rd_data", 32'(bus.rd_data), 32'(e));
    end
    rd_pend = rd_chk;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk) #1;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
`ifdef SNN_ECHO_EN
    if (m_state == 0 && !bus.tx_busy) exp_tx.push_back(b);
`endif
    if (m_state == 0) begin
      if (m_cnt == FB - 1) begin
        m_cnt = 0;
        m_state = 1;
      end else m_cnt++;
    end
    @(posedge clk) #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e);
    @(posedge clk) #1;
    bus.rd_addr = a;
    rd_chk = 1'b1;
    exp_rd.push_back(e);
    @(posedge clk) #1;
    rd_chk = 1'b0;
  endtask

  task automatic pulse_result(input logic [7:0] r);
    @(posedge clk) #1;
    bus.result_vld = 1'b1;
    bus.result     = r;
    if (m_state == 1) begin
      exp_tx.push_back(r);
      m_state = 0;
    end
    @(posedge clk) #1;
    bus.result_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk) #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    m_state = 0;
    m_cnt = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_rdy = 1'b0;
    bus.rx_data = '0;
    bus.tx_busy = 1'b0;
    bus.rd_addr = '0;
    bus.result_vld = 1'b0;
    bus.result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_frame_rdy", 32'(bus.frame_rdy), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);

    // Frame 1 load and read back
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk) chk("frame_rdy_before_last", 32'(bus.frame_rdy), 0);
    send_byte(8'h44);
    @(negedge clk) chk("frame_rdy_after_last", 32'(bus.frame_rdy), 1);
    rd(0, 8'h11); rd(1, 8'h22); rd(2, 8'h33); rd(3, 8'h44);

    // Extra byte while FULL
    chk("overrun_pre", 32'(bus.overrun), 0);
    send_byte(8'h55);
    @(negedge clk);
    chk("overrun_set", 32'(bus.overrun), 1);
    chk("frame_rdy_hold", 32'(bus.frame_rdy), 1);
    rd(0, 8'h11);

    // Result with transmitter idle
    pulse_result(8'h07);
    @(negedge clk);
    chk("send_tx_start", 32'(bus.tx_start), 1);
    chk("send_tx_data", 32'(bus.tx_data), 32'h07);
    chk("send_led", 32'(bus.led), 32'h07);
    chk("send_frame_rdy", 32'(bus.frame_rdy), 0);
    @(negedge clk);
    chk("send_one_cycle", 32'(bus.tx_start), 0);
    chk("send_tx_data_hold", 32'(bus.tx_data), 32'h07);

    // Frame 2 loads from address 0
    send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    @(negedge clk);
    chk("frame2_rdy", 32'(bus.frame_rdy), 1);
    chk("overrun_sticky", 32'(bus.overrun), 1);
    rd(0, 8'hB0); rd(3, 8'hB3);

    // Result while the transmitter is busy for 20 cycles
    @(posedge clk) #1 bus.tx_busy = 1'b1;
    pulse_result(8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) chk("tx_held_off", 32'(bus.tx_start), 0);
    end
    chk("busy_led", 32'(bus.led), 32'h5A);
    chk("busy_frame_rdy", 32'(bus.frame_rdy), 0);
    @(posedge clk) #1 bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("busy_release_tx_start", 32'(bus.tx_start), 1);
    chk("busy_release_tx_data", 32'(bus.tx_data), 32'h5A);
    @(negedge clk) chk("busy_one_cycle", 32'(bus.tx_start), 0);

    // Overrun clears only through reset
    chk("overrun_before_rst", 32'(bus.overrun), 1);
    do_reset();
    @(negedge clk);
    chk("overrun_cleared", 32'(bus.overrun), 0);
    chk("rst2_led", 32'(bus.led), 0);
    chk("rst2_tx_start", 32'(bus.tx_start), 0);

    // result_vld outside FULL is ignored
    pulse_result(8'hEE);
    @(negedge clk) chk("ignored_result_led", 32'(bus.led), 0);

    // Partial frame discarded by reset
    send_byte(8'hC1); send_byte(8'hC2);
    do_reset();
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
    @(negedge clk) chk("partial_frame_rdy", 32'(bus.frame_rdy), 0);
    send_byte(8'hA3);
    @(negedge clk) chk("refill_frame_rdy", 32'(bus.frame_rdy), 1);
    rd(0, 8'hA0); rd(1, 8'hA1); rd(2, 8'hA2); rd(3, 8'hA3);

    // Byte and result in the same FULL cycle
    @(posedge clk) #1;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h99;
    bus.result_vld = 1'b1; bus.result = 8'h3E;
    exp_tx.push_back(8'h3E);
    m_state = 0;
    @(posedge clk) #1;
    bus.rx_rdy = 1'b0; bus.result_vld = 1'b0;
    @(negedge clk);
    chk("both_tx_start", 32'(bus.tx_start), 1);
    chk("both_led", 32'(bus.led), 32'h3E);
    chk("both_overrun", 32'(bus.overrun), 1);
    rd(0, 8'hA0); rd(1, 8'hA1);

    // Echo behaviour (absent in the default build)
    send_byte(8'h3C);
    @(negedge clk);
`ifdef SNN_ECHO_EN
    chk("echo_tx_start", 32'(bus.tx_start), 1);
    chk("echo_tx_data", 32'(bus.tx_data), 32'h3C);
`else
    chk("no_echo_tx_start", 32'(bus.tx_start), 0);
`endif
    @(posedge clk) #1 bus.tx_busy = 1'b1;
    send_byte(8'h5D);
    @(negedge clk) chk("echo_skipped", 32'(bus.tx_start), 0);
    @(posedge clk) #1 bus.tx_busy = 1'b0;
    rd(0, 8'h3C); rd(1, 8'h5D);

    repeat (3) @(posedge clk);
    #1;
    chk("tx_queue_empty", 32'(exp_tx.size()), 0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
